regbank_mp: RTL and testbench

// - Parametrised multi-port successor to the scalar/predicate register bank: two banks (sel=0 scalar, sel=1 predicate).
// - Provides 2 async read ports, 2 sync write ports, a per-register busy scoreboard and a sequential clear engine.
// - Sits between decode (reads, reservations) and writeback (writes) in the core datapath.

---
 rtl/regbank_mp_if.sv | 50 +++++
 rtl/regbank_mp.sv | 99 +++++++++
 tb/tb_regbank_mp.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/regbank_mp_if.sv
// regbank_mp_if: bus bundle for the multi-port scalar/predicate register bank.
// Ports (as interface signals):
//   rd_a_sel/rd_a_addr -> rd_a_data/rd_a_busy   async read port A
//   rd_b_sel/rd_b_addr -> rd_b_data/rd_b_busy   async read port B
//   wr0_en/sel/addr/data, wr1_en/sel/addr/data   sync write ports (wr1 wins)
//   rsv_en/sel/addr                              busy reservation
//   clr_req -> clr_busy                          sequential clear sweep
// master drives requests (core side), slave is the register bank.
interface regbank_mp_if #(
    parameter int WIDTH   = 32,
    parameter int REG_SEL = 5
);
    logic               rd_a_sel;
    logic [REG_SEL-1:0] rd_a_addr;
    logic [WIDTH-1:0]   rd_a_data;
    logic               rd_a_busy;
    logic               rd_b_sel;
    logic [REG_SEL-1:0] rd_b_addr;
    logic [WIDTH-1:0]   rd_b_data;
    logic               rd_b_busy;
    logic               wr0_en;
    logic               wr0_sel;
    logic [REG_SEL-1:0] wr0_addr;
    logic [WIDTH-1:0]   wr0_data;
    logic               wr1_en;
    logic               wr1_sel;
    logic [REG_SEL-1:0] wr1_addr;
    logic [WIDTH-1:0]   wr1_data;
    logic               rsv_en;
    logic               rsv_sel;
    logic [REG_SEL-1:0] rsv_addr;
    logic               clr_req;
    logic               clr_busy;

    modport master (
        output rd_a_sel, rd_a_addr, rd_b_sel, rd_b_addr,
        output wr0_en, wr0_sel, wr0_addr, wr0_data,
        output wr1_en, wr1_sel, wr1_addr, wr1_data,
        output rsv_en, rsv_sel, rsv_addr, clr_req,
        input  rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, clr_busy
    );

    modport slave (
        input  rd_a_sel, rd_a_addr, rd_b_sel, rd_b_addr,
        input  wr0_en, wr0_sel, wr0_addr, wr0_data,
        input  wr1_en, wr1_sel, wr1_addr, wr1_data,
        input  rsv_en, rsv_sel, rsv_addr, clr_req,
        output rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, clr_busy
    );
endinterface

// File: rtl/regbank_mp.sv
// regbank_mp: two-bank (scalar sel=0, predicate sel=1) register file with
// 2 async read ports, 2 sync write ports, busy scoreboard and clear sweep.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous active-high reset (starts a full clear sweep)
//   bus    regbank_mp_if.slave  read/write/reserve/clear signals
// Optional feature: define REGBANK_BYPASS_EN for same-cycle write-to-read
// forwarding (wr1 over wr0); undefined, reads return the stored value.
module regbank_mp #(
    parameter int WIDTH   = 32,
    parameter int REG_SEL = 5
) (
    input  logic         clk,
    input  logic         reset,
    regbank_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** REG_SEL;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             state_q;
    logic [REG_SEL-1:0] clr_idx_q;
    logic               clr_busy_q;
    logic [WIDTH-1:0]   bank_q [2][DEPTH];
    logic [DEPTH-1:0]   busy_q [2];

    logic               rd_sel  [2];
    logic [REG_SEL-1:0] rd_addr [2];
    logic [WIDTH-1:0]   rd_data [2];
    logic               rd_busy [2];
    logic [1:0]         wr0_hit, wr1_hit, rsv_hit;

    assign rd_sel[0]     = bus.rd_a_sel;
    assign rd_addr[0]    = bus.rd_a_addr;
    assign rd_sel[1]     = bus.rd_b_sel;
    assign rd_addr[1]    = bus.rd_b_addr;
    assign bus.rd_a_data = rd_data[0];
    assign bus.rd_a_busy = rd_busy[0];
    assign bus.rd_b_data = rd_data[1];
    assign bus.rd_b_busy = rd_busy[1];
    assign bus.clr_busy  = clr_busy_q;

    for (genvar p = 0; p < 2; p++) begin : g_hit
        assign rsv_hit[p] = bus.rsv_en && bus.rsv_sel == rd_sel[p] && bus.rsv_addr == rd_addr[p];
`ifdef REGBANK_BYPASS_EN
        assign wr0_hit[p] = bus.wr0_en && bus.wr0_sel == rd_sel[p] && bus.wr0_addr == rd_addr[p];
        assign wr1_hit[p] = bus.wr1_en && bus.wr1_sel == rd_sel[p] && bus.wr1_addr == rd_addr[p];
`else
        assign wr0_hit[p] = 1'b0;
        assign wr1_hit[p] = 1'b0;
`endif
    end

    // A forwarded read sees the write's busy clear, unless a same-cycle reserve re-marks it.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = clr_busy_q ? '0 :
                         wr1_hit[p] ? bus.wr1_data :
                         wr0_hit[p] ? bus.wr0_data : bank_q[rd_sel[p]][rd_addr[p]];
            rd_busy[p] = clr_busy_q ? 1'b1 :
                         (wr0_hit[p] || wr1_hit[p]) ? rsv_hit[p] : busy_q[rd_sel[p]][rd_addr[p]];
        end
    end

    // Statement order gives the priorities: wr1 after wr0, reserve after both writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_idx_q  <= '0;
            clr_busy_q <= 1'b1;
            busy_q[0]  <= '0;
            busy_q[1]  <= '0;
        end else if (state_q == CLEAR) begin
            bank_q[0][clr_idx_q] <= '0;
            bank_q[1][clr_idx_q] <= '0;
            clr_idx_q            <= clr_idx_q + REG_SEL'(1);
            if (clr_idx_q == REG_SEL'(DEPTH - 1)) begin
                state_q    <= IDLE;
                clr_busy_q <= 1'b0;
            end
        end else begin
            if (bus.clr_req) begin
                state_q    <= CLEAR;
                clr_idx_q  <= '0;
                clr_busy_q <= 1'b1;
            end
            if (bus.wr0_en) begin
                bank_q[bus.wr0_sel][bus.wr0_addr] <= bus.wr0_data;
                busy_q[bus.wr0_sel][bus.wr0_addr] <= 1'b0;
            end
            if (bus.wr1_en) begin
                bank_q[bus.wr1_sel][bus.wr1_addr] <= bus.wr1_data;
                busy_q[bus.wr1_sel][bus.wr1_addr] <= 1'b0;
            end
            if (bus.rsv_en)
                busy_q[bus.rsv_sel][bus.rsv_addr] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regbank_mp.sv
// tb_regbank_mp: self-checking bench for regbank_mp (table vectors, corner
// sequences, randomized traffic against a behavioural model).
// Honours REGBANK_BYPASS_EN the same way the design does.
module tb_regbank_mp;
    localparam int W = 32;
    localparam int S = 5;
    localparam int D = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regbank_mp_if #(.WIDTH(W), .REG_SEL(S)) bus ();
    regbank_mp #(.WIDTH(W), .REG_SEL(S)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Model: plain arrays plus a countdown of remaining sweep cycles.
    logic [W-1:0] m_mem  [2][D];
    logic         m_busy [2][D];
    int           clr_left = 0;

    typedef struct {
        logic w0e; logic w0s; logic [4:0] w0a; logic [31:0] w0d;
        logic w1e; logic w1s; logic [4:0] w1a; logic [31:0] w1d;
        logic re;  logic rs;  logic [4:0] ra;
        logic qs;  logic [4:0] qa; logic [31:0] ed; logic eb;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic idle_in();
        reset = 1'b0;
        bus.wr0_en = 1'b0; bus.wr0_sel = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_sel = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.rsv_en = 1'b0; bus.rsv_sel = 1'b0; bus.rsv_addr = '0;
        bus.clr_req = 1'b0;
        bus.rd_a_sel = 1'b0; bus.rd_a_addr = '0;
        bus.rd_b_sel = 1'b0; bus.rd_b_addr = '0;
    endtask

    task automatic model_rd(input logic s, input logic [4:0] a, output logic [31:0] d, output logic b);
        if (clr_left > 0) begin
            d = '0;
            b = 1'b1;
        end else begin
            d = m_mem[s][a];
            b = m_busy[s][a];
`ifdef REGBANK_BYPASS_EN
            if (bus.wr0_en && bus.wr0_sel == s && bus.wr0_addr == a) begin
                d = bus.wr0_data;
                b = bus.rsv_en && bus.rsv_sel == s && bus.rsv_addr == a;
            end
            if (bus.wr1_en && bus.wr1_sel == s && bus.wr1_addr == a) begin
                d = bus.wr1_data;
                b = bus.rsv_en && bus.rsv_sel == s && bus.rsv_addr == a;
            end
`endif
        end
    endtask

    // Inputs are driven after a negedge; compare, take the edge, update the model.
    task automatic cycle(input bit do_chk);
        logic [31:0] d;
        logic b;
        #1;
        if (do_chk) begin
            model_rd(bus.rd_a_sel, bus.rd_a_addr, d, b);
            chk("rd_a_data", bus.rd_a_data, d);
            chk("rd_a_busy", 32'(bus.rd_a_busy), 32'(b));
            model_rd(bus.rd_b_sel, bus.rd_b_addr, d, b);
            chk("rd_b_data", bus.rd_b_data, d);
            chk("rd_b_busy", 32'(bus.rd_b_busy), 32'(b));
            chk("clr_busy", 32'(bus.clr_busy), 32'(clr_left > 0));
        end
        @(posedge clk);
        if (reset) begin
            clr_left = D;
            for (int i = 0; i < D; i++) begin
                m_busy[0][i] = 1'b0;
                m_busy[1][i] = 1'b0;
            end
        end else if (clr_left > 0) begin
            m_mem[0][D - clr_left] = '0;
            m_mem[1][D - clr_left] = '0;
            clr_left--;
        end else begin
            if (bus.clr_req) clr_left = D;
            if (bus.wr0_en) begin
                m_mem[bus.wr0_sel][bus.wr0_addr] = bus.wr0_data;
                m_busy[bus.wr0_sel][bus.wr0_addr] = 1'b0;
            end
            if (bus.wr1_en) begin
                m_mem[bus.wr1_sel][bus.wr1_addr] = bus.wr1_data;
                m_busy[bus.wr1_sel][bus.wr1_addr] = 1'b0;
            end
            if (bus.rsv_en) m_busy[bus.rsv_sel][bus.rsv_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic sweep_held(input string n);
        for (int i = 0; i < D; i++) begin
            #1;
            chk(n, 32'(bus.clr_busy), 32'd1);
            chk({n, "_data"}, bus.rd_a_data, 32'd0);
            if (i == 1) begin
                bus.wr0_en = 1'b1; bus.wr0_sel = 1'b0; bus.wr0_addr = 5'd1; bus.wr0_data = 32'h5;
            end else
                bus.wr0_en = 1'b0;
            cycle(1);
        end
        idle_in();
        #1;
        chk({n, "_end"}, 32'(bus.clr_busy), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 5'd3, 32'h4,  1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd3, 32'h4, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0,  1'b1, 5'd3, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 5'd5, 32'h7,  1'b1, 1'b0, 5'd5, 32'h9,  1'b0, 1'b0, 5'd0,  1'b0, 5'd5, 32'h9, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd2,  1'b1, 5'd2, 32'h0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 5'd2, 32'h1,  1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0,  1'b1, 5'd2, 32'h1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 5'd2, 32'h1,  1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd2,  1'b1, 5'd2, 32'h1, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd2,  1'b1, 5'd2, 32'h1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 5'd0, 32'h123, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd0, 32'h123, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0, 32'hDEADBEEF, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 5'd31, 32'hFF, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd31, 32'hFF, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 5'd7, 32'h66, 1'b1, 1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 5'd0,  1'b1, 5'd7, 32'h55, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 5'd8, 32'h11, 1'b1, 1'b0, 5'd9, 32'h22, 1'b0, 1'b0, 5'd0,  1'b0, 5'd8, 32'h11, 1'b0};

        idle_in();
        reset = 1'b1;
        cycle(0);
        reset = 1'b0;
        for (int i = 0; i < D; i++) begin
            #1;
            chk("rst_clr_busy", 32'(bus.clr_busy), 32'd1);
            chk("rst_rd_busy", 32'(bus.rd_a_busy), 32'd1);
            cycle(1);
        end
        #1;
        chk("rst_done", 32'(bus.clr_busy), 32'd0);
        for (int a = 0; a < D; a++) begin
            bus.rd_a_sel = 1'b0; bus.rd_a_addr = 5'(a);
            bus.rd_b_sel = 1'b1; bus.rd_b_addr = 5'(a);
            #1;
            chk("init_a", {bus.rd_a_data[30:0], bus.rd_a_busy}, 32'd0);
            chk("init_b", {bus.rd_b_data[30:0], bus.rd_b_busy}, 32'd0);
            cycle(1);
        end

        for (int i = 0; i < 13; i++) begin
            idle_in();
            bus.wr0_en = tbl[i].w0e; bus.wr0_sel = tbl[i].w0s; bus.wr0_addr = tbl[i].w0a; bus.wr0_data = tbl[i].w0d;
            bus.wr1_en = tbl[i].w1e; bus.wr1_sel = tbl[i].w1s; bus.wr1_addr = tbl[i].w1a; bus.wr1_data = tbl[i].w1d;
            bus.rsv_en = tbl[i].re;  bus.rsv_sel = tbl[i].rs;  bus.rsv_addr = tbl[i].ra;
            cycle(1);
            idle_in();
            bus.rd_a_sel = tbl[i].qs; bus.rd_a_addr = tbl[i].qa;
            #1;
            chk($sformatf("tbl%0d_data", i), bus.rd_a_data, tbl[i].ed);
            chk($sformatf("tbl%0d_busy", i), 32'(bus.rd_a_busy), 32'(tbl[i].eb));
            cycle(1);
        end

        idle_in();
        bus.wr0_en = 1'b1; bus.wr0_sel = 1'b0; bus.wr0_addr = 5'd4; bus.wr0_data = 32'hAB;
        bus.rd_a_sel = 1'b0; bus.rd_a_addr = 5'd4;
        #1;
`ifdef REGBANK_BYPASS_EN
        chk("bypass_data", bus.rd_a_data, 32'hAB);
        chk("bypass_busy", 32'(bus.rd_a_busy), 32'd0);
`else
        chk("bypass_data", bus.rd_a_data, 32'h0);
`endif
        cycle(1);
        bus.wr0_en = 1'b0;
        #1;
        chk("after_wr", bus.rd_a_data, 32'hAB);
        cycle(1);

        idle_in();
        bus.wr0_en = 1'b1; bus.wr0_sel = 1'b0; bus.wr0_addr = 5'd31; bus.wr0_data = 32'hFF;
        cycle(1);
        idle_in();
        bus.clr_req = 1'b1;
        cycle(1);
        idle_in();
        bus.clr_req = 1'b1;
        sweep_held("clr_sweep");
        bus.rd_a_sel = 1'b0; bus.rd_a_addr = 5'd31;
        bus.rd_b_sel = 1'b0; bus.rd_b_addr = 5'd1;
        #1;
        chk("clr_addr31", bus.rd_a_data, 32'h0);
        chk("clr_ignored_wr", bus.rd_b_data, 32'h0);
        cycle(1);

        idle_in();
        bus.clr_req = 1'b1;
        cycle(1);
        idle_in();
        for (int i = 0; i < 10; i++) cycle(1);
        reset = 1'b1;
        cycle(1);
        idle_in();
        sweep_held("rst_mid_sweep");
        cycle(1);

        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            bus.clr_req = ($urandom_range(0, 59) == 0);
            bus.wr0_en = 1'($urandom); bus.wr0_sel = 1'($urandom); bus.wr0_addr = 5'($urandom_range(0, 3)); bus.wr0_data = $urandom;
            bus.wr1_en = 1'($urandom); bus.wr1_sel = 1'($urandom); bus.wr1_addr = 5'($urandom_range(0, 3)); bus.wr1_data = $urandom;
            bus.rsv_en = 1'($urandom); bus.rsv_sel = 1'($urandom); bus.rsv_addr = 5'($urandom_range(0, 3));
            bus.rd_a_sel = 1'($urandom); bus.rd_a_addr = 5'($urandom_range(0, 3));
            bus.rd_b_sel = 1'($urandom); bus.rd_b_addr = 5'($urandom_range(0, 3));
            cycle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
